vram_write_sched: RTL
=====================

// Module: vram_write_sched
// PURPOSE
//  Owns the single write port of the frame-buffer dual-port RAM (read side belongs to vga_out).
//  Arbitrates per-dot writes from the capture front end against an on-screen-display (OSD) writer.
//  Sequences full-buffer clear sweeps on request, e.g. on a 64/80-column mode change.
//  Sits between the capture logic and the RAM; all RAM write signals come from this block, registered.
// PARAMETERS
//  ADDR_W     18      width of write address
//  FB_WORDS   192000  frame-buffer depth; valid addresses 0..FB_WORDS-1
//  CLEAR_VAL  1'b0    pixel value written during a clear sweep
// PORTS
//  dotclk      in   1       sole clock (input dot clock domain)
//  reset       in   1       synchronous, active-high reset
//  cap_valid   in   1       capture pixel present this cycle; no backpressure
//  cap_addr    in   ADDR_W  capture pixel address
//  cap_data    in   1       capture pixel value
//  clear_req   in   1       single-cycle request to start a clear sweep
//  osd_valid   in   1       OSD write request
//  osd_addr    in   ADDR_W  OSD write address
//  osd_data    in   1       OSD pixel value
//  osd_ready   out  1       OSD write accepted when osd_valid & osd_ready
//  wren        out  1       RAM write enable
//  waddr       out  ADDR_W  RAM write address
//  wdata       out  1       RAM write data
//  clear_busy  out  1       high while in CLEAR
//  clear_done  out  1       one-cycle pulse when a sweep completes
//  drop_count  out  16      saturating count of capture pixels not written
// BEHAVIOUR
//  Reset: state=NORMAL; wren=0, waddr=0, wdata=0, clear_busy=0, clear_done=0, drop_count=0, sweep ctr=0.
//  wren/waddr/wdata are registered: an input accepted in cycle N appears on the RAM port in cycle N+1.
//  FSM NORMAL -> CLEAR (clear_req) -> DONE (after last address) -> NORMAL.
//  NORMAL: cap_valid and cap_addr<FB_WORDS -> write capture pixel. Capture has absolute priority.
//  NORMAL: cap_addr>=FB_WORDS -> no write; drop_count+1.
//  NORMAL: osd_ready = ~cap_valid (combinational). OSD writes only in cycles with no capture pixel.
//  NORMAL: osd_addr>=FB_WORDS -> handshake completes, no write.
//  NORMAL: neither requester -> wren=0; waddr/wdata hold their values.
//  CLEAR: one write per cycle, waddr=ctr, wdata=CLEAR_VAL; ctr runs 0..FB_WORDS-1; clear_busy=1; osd_ready=0.
//  CLEAR: every cap_valid cycle -> drop_count+1.
//  CLEAR: clear_req while in CLEAR restarts ctr at 0 (retrigger). Sweep length = FB_WORDS cycles after last req.
//  CLEAR: ctr==FB_WORDS-1 written -> DONE.
//  DONE: wren=0, clear_done=1 for exactly one cycle, osd_ready=0, cap_valid dropped and counted.
//  DONE: next state NORMAL, or CLEAR if clear_req is high in DONE.
//  clear_req in NORMAL on the same cycle as cap_valid: the capture pixel is dropped and counted; CLEAR begins next cycle.
//  drop_count saturates at 16'hFFFF; cleared only by reset.
//  reset mid-sweep: sweep aborted, no further clear writes; the RAM keeps partial contents.
// CONFIGURATION
//  VRAM_OSD_EN defined: OSD port arbitrated as above.
//  VRAM_OSD_EN undefined: osd_ready tied 0; osd_* inputs ignored; capture and clear behaviour unchanged.
// TESTING
//  reset, cap_valid=1, addr=5, data=1 -> next cycle wren=1, waddr=5, wdata=1.
//  cap_valid=1 and osd_valid=1 same cycle -> osd_ready=0, capture written. cap_valid=0 next cycle -> OSD write follows.
//  clear_req pulse -> waddr 0..191999 on consecutive cycles, wdata=0, clear_done 1 cycle after 191999, then NORMAL.
//  10 cap_valid pixels during CLEAR, plus cap_addr=192000 in NORMAL -> drop_count=11, no such writes.
//  clear_req at ctr=1000 -> ctr back to 0; total 1001+192000 clear writes.
//  reset at ctr=500 -> wren=0 next cycle, state NORMAL.
//  VRAM_OSD_EN undefined, osd_valid=1 -> osd_ready stays 0.

Source files
------------

// File: rtl/vram_write_sched.sv
// Single write-port owner for the frame-buffer RAM: capture/OSD arbitration plus clear sweeps.
// Optional OSD port enabled by defining VRAM_OSD_EN; otherwise osd_ready is tied low.
module vram_write_sched #(
    parameter int   ADDR_W    = 18,
    parameter int   FB_WORDS  = 192000,
    parameter logic CLEAR_VAL = 1'b0
) (
    input  logic              dotclk,
    input  logic              reset,
    input  logic              cap_valid,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_data,
    input  logic              clear_req,
    input  logic              osd_valid,
    input  logic [ADDR_W-1:0] osd_addr,
    input  logic              osd_data,
    output logic              osd_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] waddr,
    output logic              wdata,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [15:0]       drop_count
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W+1)'(FB_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ctr_q, ctr_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                wdata_q, wdata_d;
    logic                clear_done_q, clear_done_d;
    logic [15:0]         drop_q, drop_d;
    logic                drop_inc;
    logic                cap_in_range;
    logic                osd_in_range;

    assign cap_in_range = ({1'b0, cap_addr} < FB_LIMIT);
    assign osd_in_range = ({1'b0, osd_addr} < FB_LIMIT);

`ifdef VRAM_OSD_EN
    assign osd_ready = (state_q == ST_NORMAL) && !cap_valid;
`else
    logic osd_unused;
    assign osd_ready  = 1'b0;
    assign osd_unused = ^{osd_valid, osd_addr, osd_data, osd_in_range};
`endif

    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        wren_d       = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        drop_inc     = 1'b0;
        clear_done_d = (state_q == ST_DONE);

        case (state_q)
            ST_NORMAL: begin
                // A clear request steals the cycle from capture; that pixel counts as dropped.
                if (cap_valid) begin
                    if (clear_req || !cap_in_range) begin
                        drop_inc = 1'b1;
                    end else begin
                        wren_d  = 1'b1;
                        waddr_d = cap_addr;
                        wdata_d = cap_data;
                    end
                end else if (osd_valid && osd_ready && osd_in_range) begin
                    wren_d  = 1'b1;
                    waddr_d = osd_addr;
                    wdata_d = osd_data;
                end
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ctr_d   = '0;
                end
            end

            ST_CLEAR: begin
                wren_d   = 1'b1;
                waddr_d  = ctr_q;
                wdata_d  = CLEAR_VAL;
                drop_inc = cap_valid;
                // Retrigger wins over completion so a late request always gets a full sweep.
                if (clear_req) begin
                    ctr_d = '0;
                end else if (ctr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end

            ST_DONE: begin
                drop_inc = cap_valid;
                ctr_d    = '0;
                state_d  = clear_req ? ST_CLEAR : ST_NORMAL;
            end

            default: begin
                state_d = ST_NORMAL;
                ctr_d   = '0;
            end
        endcase

        drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge dotclk) begin
        if (reset) begin
            state_q      <= ST_NORMAL;
            ctr_q        <= '0;
            wren_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 1'b0;
            clear_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            wren_q       <= wren_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            clear_done_q <= clear_done_d;
            drop_q       <= drop_d;
        end
    end

    assign wren       = wren_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = clear_done_q;
    assign drop_count = drop_q;

endmodule
